// File: rtl/sbus_pkg.sv
// Shared types and helpers for the S-bus memory responder: FSM states, word/index types,
// the wrap-around mask walk and a 4-bit popcount.
package sbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK_WAIT,
        ST_RD_DLY,
        ST_RD_XFER,
        ST_WR_XFER,
        ST_DONE
    } state_t;

    typedef logic [35:0] word_t;
    typedef logic [1:0]  qidx_t;

    localparam int CNT_W = 8;

    // Next selected word strictly after cur, walking start, start+1, ... mod 4.
    // Returns start once the walk has wrapped; the caller bounds the walk by popcount.
    function automatic qidx_t next_word(input qidx_t start, input logic [3:0] mask, input qidx_t cur);
        qidx_t w;
        qidx_t pos;
        next_word = start;
        pos = cur - start;
        for (int k = 3; k >= 1; k--) begin
            w = start + qidx_t'(k);
            if (k > int'(pos) && mask[w]) begin
                next_word = w;
            end
        end
    endfunction

    function automatic qidx_t first_word(input qidx_t start, input logic [3:0] mask);
        first_word = mask[start] ? start : next_word(start, mask, start);
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        popcount4 = {2'b0, m[0]} + {2'b0, m[1]} + {2'b0, m[2]} + {2'b0, m[3]};
    endfunction

endpackage

// File: rtl/sbus_mem_responder_if.sv
// S-bus memory port bundle: master is the requesting controller, slave is the memory responder.
// Pure wiring, no latency; flow control is the START/ACKN/DATA VALID handshake.
interface sbus_mem_responder_if;
    logic                mem_start_h;
    logic                mem_rd_rq_h;
    logic                mem_wr_rq_h;
    logic [3:0]          mem_rq_h;
    logic [21:0]         mem_adr_h;
    logic                mem_adr_par_h;
    logic                mem_ackn_h;
    logic                mem_data_valid_out_h;
    sbus_pkg::word_t     mem_data_out_h;
    logic                mem_data_valid_in_h;
    sbus_pkg::word_t     mem_data_in_h;
    logic                mem_busy_h;
    logic                nxm_h;
    logic                adr_par_err_h;

    modport master (
        output mem_start_h, mem_rd_rq_h, mem_wr_rq_h, mem_rq_h, mem_adr_h, mem_adr_par_h,
               mem_data_valid_in_h, mem_data_in_h,
        input  mem_ackn_h, mem_data_valid_out_h, mem_data_out_h, mem_busy_h, nxm_h, adr_par_err_h
    );

    modport slave (
        input  mem_start_h, mem_rd_rq_h, mem_wr_rq_h, mem_rq_h, mem_adr_h, mem_adr_par_h,
               mem_data_valid_in_h, mem_data_in_h,
        output mem_ackn_h, mem_data_valid_out_h, mem_data_out_h, mem_busy_h, nxm_h, adr_par_err_h
    );
endinterface

// File: rtl/sbus_word_store.sv
// Single-port 2**ADR_BITS x 36 word store; one-cycle registered read (read-before-write).
// No backpressure: a write or read is performed on every clock.
module sbus_word_store import sbus_pkg::*; #(
    parameter int ADR_BITS = 14
) (
    input  logic                clk_mem_h,
    input  logic                i_we,
    input  logic [ADR_BITS-1:0] i_addr,
    input  word_t               i_wdat,
    output word_t               o_rdat
);
    word_t r_mem [2**ADR_BITS];
    word_t r_rdat;

    always_ff @(posedge clk_mem_h) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdat;
        end
        r_rdat <= r_mem[i_addr];
    end

    assign o_rdat = r_rdat;
endmodule

// File: rtl/sbus_mem_responder.sv
// S-bus memory responder: ACKN ACK_DLY cycles after START, read words DATA_DLY after ACKN, writes paced by DATA VALID.
// Write phase waits indefinitely for the initiator; address parity checking is built only with SBUS_ADR_PAR_CHECK_EN.
module sbus_mem_responder import sbus_pkg::*; #(
    parameter int ADR_BITS = 14,
    parameter int ACK_DLY  = 3,
    parameter int DATA_DLY = 2
) (
    input  logic                  clk_mem_h,
    input  logic                  mr_reset_l,
    sbus_mem_responder_if.slave   bus
);
    state_t              r_state;
    state_t              w_nxt_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rd;
    logic [3:0]          r_mask;
    qidx_t               r_start;
    qidx_t               r_cur;
    logic [2:0]          r_left;
    logic [ADR_BITS-3:0] r_base;
    logic                r_nxm;

    logic                w_start_ok;
    logic                w_nxm;
    logic                w_par_bad;
    logic                w_accept;
    logic                w_last_ack;
    logic                w_last_dly;
    qidx_t               w_nxt_word;
    qidx_t               w_ram_word;
    logic                w_ram_we;
    word_t               w_rdat;

    assign w_start_ok = (r_state == ST_IDLE) && bus.mem_start_h
                        && (bus.mem_rd_rq_h ^ bus.mem_wr_rq_h) && (bus.mem_rq_h != 4'b0);
    assign w_nxm      = |(bus.mem_adr_h >> ADR_BITS);

`ifdef SBUS_ADR_PAR_CHECK_EN
    logic r_par_err;

    assign w_par_bad = ~^{bus.mem_adr_h, bus.mem_adr_par_h};

    always_ff @(posedge clk_mem_h) begin
        if (!mr_reset_l) begin
            r_par_err <= 1'b0;
        end else if (w_start_ok && w_par_bad) begin
            r_par_err <= 1'b1;
        end
    end

    assign bus.adr_par_err_h = r_par_err;
`else
    logic w_unused_par;

    assign w_unused_par      = bus.mem_adr_par_h;
    assign w_par_bad         = 1'b0;
    assign bus.adr_par_err_h = 1'b0;
`endif

    assign w_accept   = w_start_ok && !w_par_bad && !w_nxm;
    assign w_last_ack = (r_cnt == CNT_W'(ACK_DLY - 1));
    assign w_last_dly = (r_cnt == CNT_W'(DATA_DLY - 2));
    assign w_nxt_word = next_word(r_start, r_mask, r_cur);

    always_ff @(posedge clk_mem_h) begin
        if (!mr_reset_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_nxt_state = ST_ACK_WAIT;
            ST_ACK_WAIT: if (w_last_ack) begin
                             if (!r_rd)             w_nxt_state = ST_WR_XFER;
                             else if (DATA_DLY > 1) w_nxt_state = ST_RD_DLY;
                             else                   w_nxt_state = ST_RD_XFER;
                         end
            ST_RD_DLY:   if (w_last_dly) w_nxt_state = ST_RD_XFER;
            ST_RD_XFER:  if (r_left == 3'd1) w_nxt_state = ST_DONE;
            ST_WR_XFER:  if (bus.mem_data_valid_in_h && r_left == 3'd1) w_nxt_state = ST_DONE;
            ST_DONE:     w_nxt_state = ST_IDLE;
            default:     w_nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_ackn_h           = (r_state == ST_ACK_WAIT) && w_last_ack;
        bus.mem_data_valid_out_h = (r_state == ST_RD_XFER);
        bus.mem_busy_h           = (r_state != ST_IDLE);
        bus.nxm_h                = r_nxm;
        bus.mem_data_out_h       = (r_state == ST_RD_XFER) ? w_rdat : '0;
    end

    always_ff @(posedge clk_mem_h) begin
        if (!mr_reset_l) begin
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_mask  <= 4'b0;
            r_start <= 2'b0;
            r_cur   <= 2'b0;
            r_left  <= 3'b0;
            r_base  <= '0;
            r_nxm   <= 1'b0;
        end else begin
            r_nxm <= w_start_ok && !w_par_bad && w_nxm;

            if (w_nxt_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state == ST_ACK_WAIT || r_state == ST_RD_DLY) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                r_rd    <= bus.mem_rd_rq_h;
                r_mask  <= bus.mem_rq_h;
                r_start <= bus.mem_adr_h[1:0];
                r_cur   <= first_word(bus.mem_adr_h[1:0], bus.mem_rq_h);
                r_left  <= popcount4(bus.mem_rq_h);
                r_base  <= bus.mem_adr_h[ADR_BITS-1:2];
            end else if ((r_state == ST_RD_XFER)
                         || (r_state == ST_WR_XFER && bus.mem_data_valid_in_h)) begin
                r_cur  <= w_nxt_word;
                r_left <= r_left - 1'b1;
            end
        end
    end

    // During a read burst the store is addressed one word ahead so its registered output lines up with valid.
    assign w_ram_word = (r_state == ST_RD_XFER) ? w_nxt_word : r_cur;
    assign w_ram_we   = (r_state == ST_WR_XFER) && bus.mem_data_valid_in_h;

    sbus_word_store #(
        .ADR_BITS (ADR_BITS)
    ) u_store (
        .clk_mem_h (clk_mem_h),
        .i_we      (w_ram_we),
        .i_addr    ({r_base, w_ram_word}),
        .i_wdat    (bus.mem_data_in_h),
        .o_rdat    (w_rdat)
    );
endmodule

// File: doc/sbus_mem_responder.md
Name: sbus_mem_responder

Overview:
- Memory-side end of the S-bus memory protocol: the responder that the cache/memory-buffer controller's request logic talks to.
- Accepts START with RD/WR RQ, a 4-bit word-request mask, physical address and address parity.
- Returns ACKN, then transfers the requested words of the quadword in wrap-around order. Read data is returned with DATA VALID; write data is accepted with DATA VALID.
- Fronts a small internal word store; serves as the memory model for the MBOX and as the basis for an internal memory controller.

Parameters:
- ADR_BITS, 14, word-address width (store depth 2**ADR_BITS words).
- ACK_DLY, 3, cycles from accepted START to ACKN pulse (min 1).
- DATA_DLY, 2, cycles from ACKN to first read DATA VALID (min 1).

Ports:
- clk_mem_h  in  1  memory clock; all state changes on its rising edge
- mr_reset_l  in  1  synchronous active-low reset
- mem_start_h  in  1  request strobe
- mem_rd_rq_h  in  1  read request
- mem_wr_rq_h  in  1  write request
- mem_rq_h  in  4  word-request mask; bit i selects word i of the quadword (adr 34:35 = i)
- mem_adr_h  in  22  physical address bits 14..35 (bit 35 = LSB)
- mem_adr_par_h  in  1  odd parity over mem_adr_h
- mem_ackn_h  out  1  acknowledge pulse
- mem_data_valid_out_h  out  1  read word valid on mem_data_out_h
- mem_data_out_h  out  36  read data
- mem_data_valid_in_h  in  1  initiator write word valid
- mem_data_in_h  in  36  write data
- mem_busy_h  out  1  request in progress
- nxm_h  out  1  one-cycle pulse: address outside store, request dropped
- adr_par_err_h  out  1  sticky address parity error flag

Behaviour:
- Reset (mr_reset_l=0 at an edge): state IDLE; all outputs 0; adr_par_err_h cleared; store contents untouched. Reset mid-transfer aborts it with no further ACKN or DATA VALID.
- IDLE, mem_start_h=1: the request is accepted only when exactly one of rd/wr is set and mem_rq_h!=0. Accept latches rd/wr, mask, address and start word = adr 34:35, then goes to ACK_WAIT; mem_busy_h=1 from the next cycle.
- Malformed START (both or neither of rd/wr, or zero mask): ignored, stay IDLE.
- Any START outside IDLE: ignored.
- Address bits 14..(35-ADR_BITS) nonzero: nxm_h pulses one cycle, no ACKN, return to IDLE.
- ACK_WAIT: count ACK_DLY cycles, then mem_ackn_h=1 for exactly one cycle.
- Word order: start word, start+1, ... modulo 4, visiting only words whose mask bit is set. Count = popcount(mask), 1..4.
- READ:
  - DATA_DLY cycles after the ACKN cycle, mem_data_valid_out_h is high for one cycle per requested word on consecutive cycles.
  - mem_data_out_h carries store[{quad base, word}], registered, aligned with valid.
  - mem_data_out_h is 0 whenever valid is low.
- WRITE:
  - After ACKN, each cycle with mem_data_valid_in_h=1 writes mem_data_in_h to the next word in order.
  - Completes after popcount(mask) writes. No timeout: waits indefinitely, and only reset aborts.
  - DATA VALID before ACKN is ignored.
- DONE: one recovery cycle, mem_busy_h=0 on exit to IDLE. A START in the DONE cycle is ignored.
- States: IDLE, ACK_WAIT, RD_DLY, RD_XFER, WR_XFER, DONE.

Optional Feature:
- Macro: SBUS_ADR_PAR_CHECK_EN.
- Defined: at accept, mem_adr_h plus mem_adr_par_h must have odd parity. On failure: no ACKN, adr_par_err_h set until reset, return to IDLE.
- Undefined: parity ignored; adr_par_err_h tied 0.

Decomposition:
- Shared package sbus_pkg:
  - state enum;
  - word_t (36 bits);
  - quad word index type (2 bits);
  - next_word(start, mask, cur) function for wrap-around mask walk;
  - popcount4 function.
- Sub-module sbus_word_store: single-port synchronous RAM, 2**ADR_BITS x 36, registered read, write-enable.

Test Plan:
- Read, adr=0o000100 (word 0), mask=4'b1111, store preloaded 1,2,3,4 -> ACKN 3 cycles after START; 4 valid cycles 2 after ACKN returning 1,2,3,4.
- Read, adr word 2, mask=4'b1011 -> data order words 3,0,1 (word 2 skipped); exactly 3 valid pulses.
- Write, adr word 1, mask=4'b0110, data 0o777,0o123 with gaps between valids -> store[1]=0o777, store[2]=0o123, other words unchanged.
- START while busy, or START with rd and wr both set -> no ACKN, busy unchanged; adr beyond 2**14 words -> nxm_h pulse, no ACKN.
- Reset asserted during RD_XFER after 2 words -> no further valid pulses, busy=0; the following legal request serves normally.
- SBUS_ADR_PAR_CHECK_EN defined, even parity -> no ACKN, adr_par_err_h=1 until reset; undefined, same stimulus -> normal ACKN.
